// File: rtl/gate_truth_table_gen.sv
// rtl/gate_truth_table_gen.sv - sweeps every input combination of a selectable gate and captures its truth table
module gate_truth_table_gen #(
    parameter int N_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           mode,
    output logic [N_IN-1:0]      vec,
    output logic                 y,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

    localparam logic [2:0] MODE_AND     = 3'b000;
    localparam logic [2:0] MODE_OR      = 3'b001;
    localparam logic [2:0] MODE_NAND    = 3'b010;
    localparam logic [2:0] MODE_NOR     = 3'b011;
    localparam logic [2:0] MODE_XOR     = 3'b100;
    localparam logic [2:0] MODE_XNOR    = 3'b101;
    localparam logic [2:0] MODE_NOT     = 3'b110;
    localparam logic [2:0] MODE_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] mode_q;
    logic       start_req;
    logic       accept;
    logic       reject;

    // abort outranks start in IDLE: a simultaneous abort yields neither a run nor an error
    assign start_req = (state == IDLE) && start && !abort;
    assign accept    = start_req && (mode != MODE_ILLEGAL);
    assign reject    = start_req && (mode == MODE_ILLEGAL);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // gate evaluation uses only the mode latched at acceptance, so mode may change freely during a run
    always_comb begin
        y = 1'b0;
        case (mode_q)
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XOR:  y = ^vec;
            MODE_XNOR: y = ~^vec;
            MODE_NOT:  y = ~vec[0];
            default:   y = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; the last combination of the sweep hands over to the single DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (vec == VEC_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // sweep datapath: capture y at the current vec, then step vec (wraps to 0 naturally after the last entry)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_AND;
            vec       <= '0;
            table_out <= '0;
        end else if (accept) begin
            mode_q    <= mode;
            vec       <= '0;
            table_out <= '0;
        end else if (state == RUN) begin
            if (abort) begin
                vec       <= '0;
                table_out <= '0;
            end else begin
                table_out[vec] <= y;
                vec            <= vec + VEC_ONE;
            end
        end
    end

    // one-cycle error pulse for a start carrying the illegal mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= reject;
        end
    end

endmodule

// File: tb/tb_gate_truth_table_gen.sv
// tb/tb_gate_truth_table_gen.sv - scoreboard bench for gate_truth_table_gen at N_IN=2 and N_IN=3
module tb_gate_truth_table_gen;

    typedef struct {
        logic       is_err;
        logic [7:0] tbl;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start2, abort2;
    logic [2:0] mode2;
    logic [1:0] vec2;
    logic       y2;
    logic [3:0] tbl2;
    logic       busy2, done2, err2;

    logic       start3, abort3;
    logic [2:0] mode3;
    logic [2:0] vec3;
    logic       y3;
    logic [7:0] tbl3;
    logic       busy3, done3, err3;

    exp_t q2[$];
    exp_t q3[$];

    int pass_cnt;
    int tot_cnt;

    gate_truth_table_gen #(.N_IN(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mode(mode2),
        .vec(vec2), .y(y2), .table_out(tbl2), .busy(busy2), .done(done2), .err(err2)
    );

    gate_truth_table_gen #(.N_IN(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mode(mode3),
        .vec(vec3), .y(y3), .table_out(tbl3), .busy(busy3), .done(done3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tot_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push2(input logic is_err, input logic [3:0] tbl);
        exp_t e;
        e.is_err = is_err;
        e.tbl    = {4'b0000, tbl};
        q2.push_back(e);
    endtask

    task automatic push3(input logic is_err, input logic [7:0] tbl);
        exp_t e;
        e.is_err = is_err;
        e.tbl    = tbl;
        q3.push_back(e);
    endtask

    task automatic wait_done2(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done2) got = 1'b1;
        end
        check(name, {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done3(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done3) got = 1'b1;
            if (i == 3) mode3 = 3'b000;
        end
        check(name, {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    // monitors: every done/err pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done2 || err2) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_event", {30'd0, done2, err2}, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2_event_kind", {31'd0, err2}, {31'd0, e.is_err});
                check("dut2_table", {28'd0, tbl2}, {24'd0, e.tbl});
                check("dut2_done_err_exclusive", {31'd0, done2 & err2}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done3 || err3) begin
            if (q3.size() == 0) begin
                check("dut3_unexpected_event", {30'd0, done3, err3}, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("dut3_event_kind", {31'd0, err3}, {31'd0, e.is_err});
                check("dut3_table", {24'd0, tbl3}, {24'd0, e.tbl});
            end
        end
    end

    initial begin
        logic [3:0] nor_y;
        pass_cnt = 0;
        tot_cnt  = 0;
        rst = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; mode2 = 3'b000;
        start3 = 1'b0; abort3 = 1'b0; mode3 = 3'b000;
        nor_y = 4'b0001;

        #12;
        check("reset_vec", {30'd0, vec2}, 32'd0);
        check("reset_table", {28'd0, tbl2}, 32'd0);
        check("reset_flags", {29'd0, busy2, done2, err2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // NOR sweep with per-step vec/y trace
        start2 = 1'b1; mode2 = 3'b011; push2(1'b0, 4'b0001);
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nor_busy_%0d", i), {31'd0, busy2}, 32'd1);
            check($sformatf("nor_vec_%0d", i), {30'd0, vec2}, i);
            check($sformatf("nor_y_%0d", i), {31'd0, y2}, {31'd0, nor_y[i]});
            @(negedge clk);
        end
        check("nor_done_cycle", {30'd0, done2, busy2}, 32'd2);
        @(negedge clk);

        // OR then NAND back to back; the second start clears the table
        start2 = 1'b1; mode2 = 3'b001; push2(1'b0, 4'b1110);
        @(negedge clk);
        start2 = 1'b0;
        wait_done2("or_done_timeout");
        start2 = 1'b1; mode2 = 3'b010; push2(1'b0, 4'b0111);
        @(negedge clk);
        start2 = 1'b0;
        check("nand_table_cleared", {28'd0, tbl2}, 32'd0);
        wait_done2("nand_done_timeout");

        // illegal mode: error pulse, no run, table kept
        start2 = 1'b1; mode2 = 3'b111; push2(1'b1, 4'b0111);
        @(negedge clk);
        start2 = 1'b0;
        check("illegal_busy", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        check("illegal_err_one_cycle", {31'd0, err2}, 32'd0);

        // abort at vec==2 in a NOR run
        start2 = 1'b1; mode2 = 3'b011;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_vec_before", {30'd0, vec2}, 32'd2);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        check("abort_state", {28'd0, busy2, vec2, done2}, 32'd0);
        check("abort_table", {28'd0, tbl2}, 32'd0);
        repeat (6) @(negedge clk);

        // XOR sweep at N_IN=3, mode toggled mid-run inside wait_done3
        start3 = 1'b1; mode3 = 3'b100; push3(1'b0, 8'b10010110);
        @(negedge clk);
        start3 = 1'b0;
        wait_done3("xor_done_timeout");

        // asynchronous reset mid-run, then AND run
        start2 = 1'b1; mode2 = 3'b011;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {25'd0, busy2, done2, err2, vec2, y2 & 1'b0}, 32'd0);
        check("async_rst_table", {28'd0, tbl2}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        start2 = 1'b1; mode2 = 3'b000; push2(1'b0, 4'b1000);
        @(negedge clk);
        start2 = 1'b0;
        check("post_rst_accept", {31'd0, busy2}, 32'd1);
        wait_done2("and_done_timeout");

        repeat (6) @(negedge clk);
        check("dut2_queue_drained", q2.size(), 32'd0);
        check("dut3_queue_drained", q3.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
